// File: rtl/muldiv_unit.sv
// RV32 M-extension multiply/divide unit.
// Single-cycle multiply, iterative restoring divide.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_func3,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            busy
);

  localparam int ITER = XLEN / DIV_BITS;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_dvs;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_is_rem;
  logic [XLEN-1:0] r_out_data;
  logic [4:0]      r_out_rd;

  logic              w_acc;
  logic              w_is_div;
  logic              w_sgn_div;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic              w_s1;
  logic              w_s2;
  logic [2*XLEN-1:0] w_ma;
  logic [2*XLEN-1:0] w_mb;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_fast_res;
  logic              w_neg1;
  logic              w_neg2;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN:0]     w_tr;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_fix_q;
  logic [XLEN-1:0]   w_fix_r;
  logic [XLEN-1:0]   w_fix;

  assign in_ready  = (r_state == IDLE) && !flush && rst;
  assign w_acc     = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_out_data;
  assign out_rd    = r_out_rd;

  assign w_is_div  = in_func3[2];
  assign w_sgn_div = !in_func3[0];
  assign w_div0    = (in_src2 == '0);
  assign w_ovf     = w_sgn_div
                   && (in_src1 == {1'b1, {(XLEN-1){1'b0}}})
                   && (in_src2 == '1);
  assign w_fast    = !w_is_div || w_div0 || w_ovf;

  // Full-width product with per-op operand sign extension
  always_comb begin
    w_s1 = (in_func3 == 3'b001) || (in_func3 == 3'b010);
    w_s2 = (in_func3 == 3'b001);
    w_ma = {{XLEN{w_s1 & in_src1[XLEN-1]}}, in_src1};
    w_mb = {{XLEN{w_s2 & in_src2[XLEN-1]}}, in_src2};
    w_prod = w_ma * w_mb;
    if (in_func3[1:0] == 2'b00) begin
      w_mul_res = w_prod[XLEN-1:0];
    end else begin
      w_mul_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  // Result for ops finishing one cycle after accept
  always_comb begin
    w_fast_res = w_mul_res;
    if (w_is_div) begin
      if (w_div0) begin
        w_fast_res = in_func3[1] ? in_src1 : '1;
      end else begin
        w_fast_res = in_func3[1] ? '0 : in_src1;
      end
    end
  end

  // Operand magnitudes for signed divide
  always_comb begin
    w_neg1 = w_sgn_div & in_src1[XLEN-1];
    w_neg2 = w_sgn_div & in_src2[XLEN-1];
    w_abs1 = w_neg1 ? -in_src1 : in_src1;
    w_abs2 = w_neg2 ? -in_src2 : in_src2;
  end

  // DIV_BITS restoring steps; quotient shifts in as dividend shifts out
  always_comb begin
    w_rem  = r_rem;
    w_quo  = r_quo;
    w_tr   = '0;
    w_diff = '0;
    for (int k = 0; k < DIV_BITS; k++) begin
      w_tr   = {w_rem, w_quo[XLEN-1]};
      w_diff = w_tr - {1'b0, r_dvs};
      w_quo  = {w_quo[XLEN-2:0], !w_diff[XLEN]};
      w_rem  = w_diff[XLEN] ? w_tr[XLEN-1:0] : w_diff[XLEN-1:0];
    end
  end

  // Sign restoration of quotient and remainder
  always_comb begin
    w_fix_q = r_neg_q ? -r_quo : r_quo;
    w_fix_r = r_neg_r ? -r_rem : r_rem;
    w_fix   = r_is_rem ? w_fix_r : w_fix_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          w_next = w_fast ? DONE : CALC;
        end
      end
      CALC: begin
        if (flush) begin
          w_next = IDLE;
        end else if (r_cnt == CW'(ITER - 1)) begin
          w_next = FIX;
        end
      end
      FIX: begin
        w_next = flush ? IDLE : DONE;
      end
      DONE: begin
        if (flush || out_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath registers: capture, iterate, finish
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_is_rem   <= 1'b0;
      r_out_data <= '0;
      r_out_rd   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_acc) begin
            r_out_rd <= in_rd;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs1;
            r_dvs    <= w_abs2;
            r_neg_q  <= w_neg1 ^ w_neg2;
            r_neg_r  <= w_neg1;
            r_is_rem <= in_func3[1];
            if (w_fast) begin
              r_out_data <= w_fast_res;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem;
          r_quo <= w_quo;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          r_out_data <= w_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit.
// Runs a DIV_BITS=1 and a DIV_BITS=4 instance.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_func3 = 3'd0;
  logic [31:0] in_src1 = 32'd0;
  logic [31:0] in_src2 = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_data;
  logic [4:0]  out_rd;

  logic        b_in_valid = 1'b0;
  logic        b_flush = 1'b0;
  logic        b_out_ready = 1'b0;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [31:0] b_out_data;
  logic [4:0]  b_out_rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .DIV_BITS(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_func3(in_func3), .in_src1(in_src1),
    .in_src2(in_src2), .in_rd(in_rd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .busy(busy)
  );

  muldiv_unit #(.XLEN(32), .DIV_BITS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_func3(in_func3), .in_src1(in_src1),
    .in_src2(in_src2), .in_rd(in_rd),
    .flush(b_flush),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_rd(b_out_rd),
    .busy(b_busy)
  );

  task automatic run_op(input bit sel, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat,
                        output logic [31:0] res, output logic [4:0] ord);
    @(negedge clk);
    in_func3 = f; in_src1 = a; in_src2 = b; in_rd = rd;
    if (sel) b_in_valid = 1'b1;
    else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; b_in_valid = 1'b0;
    lat = 1;
    while (!(sel ? b_out_valid : out_valid) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = sel ? b_out_data : out_data;
    ord = sel ? b_out_rd : out_rd;
    if (sel) b_out_ready = 1'b1;
    else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1; in_func3 = 3'b000;
    in_src1 = 32'd3; in_src2 = 32'd4; in_rd = 5'd1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
    end
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_busy_valid: got %b%b want 00", busy, out_valid);
    end
    tests++;
    if (out_data !== 32'd0 || out_rd !== 5'd0) begin
      fails++;
      $display("FAIL rst_out: got %h/%0d want 0/0", out_data, out_rd);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_release: got rdy=%b busy=%b want 1/0", in_ready, busy);
    end
  endtask

  task automatic test_mul();
    int lat;
    logic [31:0] r;
    logic [4:0] d;
    run_op(1'b0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, lat, r, d);
    tests++;
    if (r !== 32'h0 || lat !== 1) begin
      fails++; $display("FAIL mulh: got %h lat %0d want 0 lat 1", r, lat);
    end
    run_op(1'b0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFFE || lat !== 1) begin
      fails++;
      $display("FAIL mulhu: got %h lat %0d want fffffffe lat 1", r, lat);
    end
    run_op(1'b0, 3'b000, 32'd7, 32'hFFFFFFFD, 5'd4, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFEB || d !== 5'd4) begin
      fails++; $display("FAIL mul: got %h rd %0d want ffffffeb rd 4", r, d);
    end
    run_op(1'b0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL mulhsu: got %h want ffffffff", r);
    end
  endtask

  task automatic test_div();
    int lat;
    logic [31:0] r;
    logic [4:0] d;
    run_op(1'b0, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd6, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFFD || lat !== 34) begin
      fails++;
      $display("FAIL div: got %h lat %0d want fffffffd lat 34", r, lat);
    end
    run_op(1'b0, 3'b110, 32'hFFFFFFF9, 32'd2, 5'd7, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFFF || d !== 5'd7) begin
      fails++; $display("FAIL rem: got %h rd %0d want ffffffff rd 7", r, d);
    end
    run_op(1'b0, 3'b100, 32'd7, 32'hFFFFFFFE, 5'd8, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFFD) begin
      fails++; $display("FAIL div_negdvs: got %h want fffffffd", r);
    end
    run_op(1'b0, 3'b110, 32'd7, 32'hFFFFFFFE, 5'd8, lat, r, d);
    tests++;
    if (r !== 32'd1) begin
      fails++; $display("FAIL rem_negdvs: got %h want 1", r);
    end
    run_op(1'b0, 3'b111, 32'd100, 32'd7, 5'd9, lat, r, d);
    tests++;
    if (r !== 32'd2) begin
      fails++; $display("FAIL remu: got %h want 2", r);
    end
    run_op(1'b0, 3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd9, lat, r, d);
    tests++;
    if (r !== 32'd0 || lat !== 34) begin
      fails++; $display("FAIL divu_big: got %h lat %0d want 0 lat 34", r, lat);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [31:0] r;
    logic [4:0] d;
    run_op(1'b0, 3'b101, 32'd5, 32'd0, 5'd10, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFFF || lat !== 1) begin
      fails++;
      $display("FAIL divu0: got %h lat %0d want ffffffff lat 1", r, lat);
    end
    run_op(1'b0, 3'b111, 32'd5, 32'd0, 5'd11, lat, r, d);
    tests++;
    if (r !== 32'd5 || lat !== 1) begin
      fails++; $display("FAIL remu0: got %h lat %0d want 5 lat 1", r, lat);
    end
    run_op(1'b0, 3'b110, 32'hFFFFFFF9, 32'd0, 5'd12, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFF9) begin
      fails++; $display("FAIL rem0: got %h want fffffff9", r);
    end
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] r;
    logic [4:0] d;
    run_op(1'b0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd13, lat, r, d);
    tests++;
    if (r !== 32'h80000000 || lat !== 1) begin
      fails++;
      $display("FAIL div_ovf: got %h lat %0d want 80000000 lat 1", r, lat);
    end
    run_op(1'b0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd14, lat, r, d);
    tests++;
    if (r !== 32'd0 || lat !== 1) begin
      fails++; $display("FAIL rem_ovf: got %h lat %0d want 0 lat 1", r, lat);
    end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    logic [31:0] r;
    logic [4:0] d;
    @(negedge clk);
    in_func3 = 3'b101; in_src1 = 32'd1000; in_src2 = 32'd3; in_rd = 5'd20;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL flush_pre_busy: got %b want 1", busy);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: got busy=%b vld=%b want 0/0", busy, out_valid);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL flush_stale: got %0d valid cycles want 0", seen);
    end
    run_op(1'b0, 3'b101, 32'd100, 32'd7, 5'd21, lat, r, d);
    tests++;
    if (r !== 32'd14 || d !== 5'd21 || lat !== 34) begin
      fails++;
      $display("FAIL flush_new: got %0d rd %0d lat %0d want 14 rd 21 lat 34",
               r, d, lat);
    end
    @(negedge clk);
    in_func3 = 3'b000; in_valid = 1'b1; flush = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL flush_wins: got busy %b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    @(negedge clk);
    in_func3 = 3'b000; in_src1 = 32'd6; in_src2 = 32'd7; in_rd = 5'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_func3 = 3'b101; in_src1 = 32'd9; in_src2 = 32'd2; in_rd = 5'd30;
    bad = 0;
    repeat (5) begin
      if (out_valid !== 1'b1 || out_data !== 32'd42
          || out_rd !== 5'd3 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd42) begin
      fails++;
      $display("FAIL hold_xfer: got vld=%b %0d want 1 42", out_valid, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL hold_after: got vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_flush_done();
    @(negedge clk);
    in_func3 = 3'b000; in_src1 = 32'd2; in_src2 = 32'd3; in_rd = 5'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b1; out_ready = 1'b1;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'd6) begin
      fails++;
      $display("FAIL flush_done_xfer: got vld=%b %0d want 1 6", out_valid, out_data);
    end
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    tests++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_done_idle: got busy=%b vld=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    @(negedge clk);
    in_func3 = 3'b100; in_src1 = 32'd77; in_src2 = 32'd5; in_rd = 5'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0 || out_data !== 32'd0 || out_rd !== 5'd0) begin
      fails++;
      $display("FAIL rst_mid: got busy=%b %h rd %0d want 0 0 0",
               busy, out_data, out_rd);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL rst_mid_out: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_div4();
    int lat;
    logic [31:0] r;
    logic [4:0] d;
    run_op(1'b1, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd17, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFFD || lat !== 10 || d !== 5'd17) begin
      fails++;
      $display("FAIL div4: got %h lat %0d rd %0d want fffffffd lat 10 rd 17",
               r, lat, d);
    end
    run_op(1'b1, 3'b110, 32'hFFFFFFF9, 32'd2, 5'd18, lat, r, d);
    tests++;
    if (r !== 32'hFFFFFFFF || lat !== 10) begin
      fails++;
      $display("FAIL rem4: got %h lat %0d want ffffffff lat 10", r, lat);
    end
    run_op(1'b1, 3'b101, 32'd100, 32'd7, 5'd19, lat, r, d);
    tests++;
    if (r !== 32'd14) begin
      fails++; $display("FAIL divu4: got %0d want 14", r);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_flush();
    test_backpressure();
    test_flush_done();
    test_reset_mid_calc();
    test_div4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
